// File: rtl/register_write_arbiter.sv
// Round-robin write controller for one shared DATA_W-bit register: grant, capture, commit, ack.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module register_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] d,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         q,
    output logic                      busy,
    output logic                      q_valid
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: req is a level held by the requester; the one-cycle ack pulse
    // marks the edge at which its captured data became visible on q.
    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_n;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]    win_q, win_n;
    logic [DATA_W-1:0]   hold, hold_n;
    logic [NUM_REQ-1:0]  gnt_n, ack_n;
    logic [DATA_W-1:0]   q_n;
    logic                busy_n, q_valid_n;
    logic                found;
    logic [PTR_W-1:0]    win_sel;
    int                  idx;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        win_sel = rr_ptr;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_sel = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        win_n     = win_q;
        hold_n    = hold;
        gnt_n     = '0;
        ack_n     = '0;
        q_n       = q;
        busy_n    = 1'b0;
        q_valid_n = q_valid;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    win_n   = win_sel;
                    hold_n  = d[win_sel*DATA_W +: DATA_W];
                    gnt_n   = NUM_REQ'(1) << win_sel;
                    busy_n  = 1'b1;
                end
            end
            GRANT: begin
                state_n   = IDLE;
                q_n       = hold;
                ack_n     = NUM_REQ'(1) << win_q;
                q_valid_n = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
                rr_ptr_n  = '0;
`else
                rr_ptr_n  = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            win_q   <= '0;
            hold    <= '0;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            busy    <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            win_q   <= win_n;
            hold    <= hold_n;
            gnt     <= gnt_n;
            ack     <= ack_n;
            q       <= q_n;
            busy    <= busy_n;
            q_valid <= q_valid_n;
        end
    end
endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: vector table, corner-case sequences, randomized model check.
module tb_register_write_arbiter;
    localparam int N = 4;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q;
    logic           busy, q_valid;

    int checks = 0;
    int errors = 0;

    register_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .d(d),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*W-1:0] d;
        logic [N-1:0]   gnt;
        logic [N-1:0]   ack;
        logic [W-1:0]   q;
        logic           busy;
        logic           qv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ea,
                             input logic [W-1:0] eq, input logic eb, input logic ev);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".ack"}, 32'(ack), 32'(ea));
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(ev));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        d     = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic add(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] dd,
                       input logic [N-1:0] g, input logic [N-1:0] a, input logic [W-1:0] qq,
                       input logic b, input logic v);
        vec_t x;
        x.rst = r; x.req = rq; x.d = dd; x.gnt = g; x.ack = a; x.q = qq; x.busy = b; x.qv = v;
        vecs.push_back(x);
    endtask

    // Transaction-level reference state for the randomized phase
    logic [W-1:0] exp_q[$];
    int           m_ptr, m_win;
    logic         m_pending, m_valid;
    logic [W-1:0] m_q;

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    initial begin
        logic [N*W-1:0] dseq, d55;
        logic [N-1:0]   eg, ea;
        int             w;
        reset = 1'b1;
        req   = '0;
        d     = '0;
        #1;
        chk("reset.q", 32'(q), 0);
        chk("reset.busy", 32'(busy), 0);
        step();
        reset = 1'b0;

        dseq = {7'h04, 7'h03, 7'h02, 7'h01};
        d55  = {7'h00, 7'h00, 7'h55, 7'h00};
`ifndef ARB_FIXED_PRIO_EN
        // Single write, then round-robin over all four, then wrap-around from rr_ptr=3
        add(1, 4'b0000, '0,   4'b0000, 4'b0000, 7'h00, 0, 0);
        add(0, 4'b0010, d55,  4'b0010, 4'b0000, 7'h00, 1, 0);
        add(0, 4'b0000, d55,  4'b0000, 4'b0010, 7'h55, 0, 1);
        add(1, 4'b0000, '0,   4'b0000, 4'b0000, 7'h00, 0, 0);
        add(0, 4'b1111, dseq, 4'b0001, 4'b0000, 7'h00, 1, 0);
        add(0, 4'b1111, dseq, 4'b0000, 4'b0001, 7'h01, 0, 1);
        add(0, 4'b1111, dseq, 4'b0010, 4'b0000, 7'h01, 1, 1);
        add(0, 4'b1111, dseq, 4'b0000, 4'b0010, 7'h02, 0, 1);
        add(0, 4'b1111, dseq, 4'b0100, 4'b0000, 7'h02, 1, 1);
        add(0, 4'b1111, dseq, 4'b0000, 4'b0100, 7'h03, 0, 1);
        add(0, 4'b1111, dseq, 4'b1000, 4'b0000, 7'h03, 1, 1);
        add(0, 4'b1111, dseq, 4'b0000, 4'b1000, 7'h04, 0, 1);
        add(0, 4'b1111, dseq, 4'b0001, 4'b0000, 7'h04, 1, 1);
        add(0, 4'b0000, dseq, 4'b0000, 4'b0001, 7'h01, 0, 1);
        add(0, 4'b0000, dseq, 4'b0000, 4'b0000, 7'h01, 0, 1);
        add(0, 4'b0100, dseq, 4'b0100, 4'b0000, 7'h01, 1, 1);
        add(0, 4'b1001, dseq, 4'b0000, 4'b0100, 7'h03, 0, 1);
        add(0, 4'b1001, dseq, 4'b1000, 4'b0000, 7'h03, 1, 1);
        add(0, 4'b1001, dseq, 4'b0000, 4'b1000, 7'h04, 0, 1);
        add(0, 4'b1001, dseq, 4'b0001, 4'b0000, 7'h04, 1, 1);
        add(0, 4'b0000, dseq, 4'b0000, 4'b0001, 7'h01, 0, 1);
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            d     = vecs[i].d;
            step();
            reset = 1'b0;
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].q,
                      vecs[i].busy, vecs[i].qv);
        end
`endif

        // Reset in the middle of a grant abandons the write
        do_reset();
        req = 4'b0001;
        d   = {7'h00, 7'h00, 7'h00, 7'h7F};
        step();
        chk("midrst.gnt_before", 32'(gnt), 32'(4'b0001));
        reset = 1'b1;
        #1;
        check_all("midrst.async", 4'b0000, 4'b0000, 7'h00, 0, 0);
        step();
        reset = 1'b0;
        req   = 4'b0000;
        step();
        check_all("midrst.after", 4'b0000, 4'b0000, 7'h00, 0, 0);
        req = 4'b0001;
        d   = {7'h00, 7'h00, 7'h00, 7'h11};
        step();
        check_all("midrst.regrant", 4'b0001, 4'b0000, 7'h00, 1, 0);
        req = 4'b0000;
        step();
        check_all("midrst.commit", 4'b0000, 4'b0001, 7'h11, 0, 1);

        // Drop req and change d right after the grant
        do_reset();
        req = 4'b0100;
        d   = {7'h00, 7'h2A, 7'h00, 7'h00};
        step();
        check_all("drop.gnt", 4'b0100, 4'b0000, 7'h00, 1, 0);
        req = 4'b0000;
        d   = {7'h00, 7'h15, 7'h00, 7'h00};
        step();
        check_all("drop.commit", 4'b0000, 4'b0100, 7'h2A, 0, 1);

`ifdef ARB_FIXED_PRIO_EN
        // Requester 0 starves requester 2 while it keeps requesting
        do_reset();
        req = 4'b0101;
        d   = {7'h00, 7'h0C, 7'h00, 7'h0A};
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 0) chk("fixed.gnt", 32'(gnt), 32'(4'b0001));
            else            chk("fixed.ack", 32'(ack), 32'(4'b0001));
        end
        req = 4'b0100;
        step();
        chk("fixed.gnt2", 32'(gnt), 32'(4'b0100));
        step();
        chk("fixed.ack2", 32'(ack), 32'(4'b0100));
        chk("fixed.q2", 32'(q), 32'(7'h0C));
`endif

        // Randomized run against the transaction-level model
        do_reset();
        exp_q.delete();
        m_ptr = 0; m_pending = 0; m_valid = 0; m_q = '0; m_win = 0;
        for (int c = 0; c < 400; c++) begin
            req   = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            d     = {$urandom(), $urandom()};
            reset = ($urandom_range(0, 60) == 0);
            eg = '0;
            ea = '0;
            if (reset) begin
                exp_q.delete();
                m_ptr = 0; m_pending = 0; m_valid = 0; m_q = '0;
            end else if (m_pending) begin
                ea        = N'(1) << m_win;
                m_q       = exp_q.pop_front();
                m_valid   = 1;
                m_pending = 0;
`ifdef ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_win + 1) % N;
`endif
            end else begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    eg        = N'(1) << w;
                    m_win     = w;
                    m_pending = 1;
                    exp_q.push_back(d[w*W +: W]);
                end
            end
            step();
            reset = 1'b0;
            check_all($sformatf("rand%0d", c), eg, ea, m_q, m_pending, m_valid);
            chk("rand.excl", 32'(gnt & ack), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
